// File: rtl/regfile_rw_pkg.sv
// Shared register-file constants and sequencer state encoding.
package regfile_rw_pkg;

    localparam logic [31:0] ZERO_WORD  = 32'h0;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_NUM    = 32;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mem.sv
// Reset-less 1-write / 3-read storage array, suitable for distributed RAM mapping.
module regfile_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    input  logic [ADDR_W-1:0] raddr_c_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem[raddr_a_i];
    assign rdata_b_o = mem[raddr_b_i];
    assign rdata_c_o = mem[raddr_c_i];

endmodule

// File: rtl/regfile_rw.sv
// RV32I integer register file: zero/bypass read muxing, post-reset clear sweep,
// registered debug read port.
module regfile_rw
    import regfile_rw_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic [ADDR_W-1:0] wd_addr_i,
    input  logic [DATA_W-1:0] wd_data_i,
    input  logic              reg_wen_i,
    output logic              init_busy_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] dbg_q, dbg_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rs1, mem_rs2, mem_dbg;
    logic              run;

    // Reads are forced to zero while reset is held, before state has settled.
    assign run = (state_q == StRun) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            ptr_q   <= ADDR_W'(1);
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dbg_q   <= dbg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wd_addr_i;
        mem_wdata = wd_data_i;
        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == PtrLast) begin
                    state_d = StRun;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            StRun: begin
                mem_we = reg_wen_i && (wd_addr_i != '0);
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (run && rs1_addr_i != '0) begin
            rs1_data_o = (reg_wen_i && wd_addr_i == rs1_addr_i) ? wd_data_i : mem_rs1;
        end
        if (run && rs2_addr_i != '0) begin
            rs2_data_o = (reg_wen_i && wd_addr_i == rs2_addr_i) ? wd_data_i : mem_rs2;
        end
    end

    // Debug port deliberately has no bypass: it sees the array as of this edge.
    always_comb begin
        dbg_d = '0;
        if (state_q == StRun && dbg_addr_i != '0) begin
            dbg_d = mem_dbg;
        end
    end

    assign init_busy_o = rst || (state_q == StInit);
    assign dbg_data_o  = dbg_q;

    regfile_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .we_i     (mem_we),
        .waddr_i  (mem_waddr),
        .wdata_i  (mem_wdata),
        .raddr_a_i(rs1_addr_i),
        .raddr_b_i(rs2_addr_i),
        .raddr_c_i(dbg_addr_i),
        .rdata_a_o(mem_rs1),
        .rdata_b_o(mem_rs2),
        .rdata_c_o(mem_dbg)
    );

endmodule
